// File: rtl/dvp_8bit_tx.sv
// dvp_8bit_tx: 8-bit DVP-style video transmitter.
// Streams RGB888 pixels as RGB565 byte pairs (high byte first) with vs_o/de_o
// framing. Every line in every vertical region lasts 2*H_ACTIVE + H_BLANK pclk.
// Optional feature macro: DVP_TX_COLORBAR_EN adds an internal 8-bar colour
// pattern selected by pattern_sel (latched at frame start). Without the macro
// pattern_sel has no effect.
module dvp_8bit_tx #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pixel_valid,
    input  logic [23:0] pixel_data,
    output logic        pixel_ready,
    input  logic        pattern_sel,
    output logic        vs_o,
    output logic        de_o,
    output logic [7:0]  pdata_o,
    output logic        sof_o,
    output logic        underrun_o
);

    localparam int LP     = 2 * H_ACTIVE + H_BLANK;
    localparam int HW     = $clog2(LP);
    localparam int PXW    = HW - 1;
    localparam int LMAX_A = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
    localparam int LMAX_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int LMAX   = (LMAX_A > LMAX_B) ? LMAX_A : LMAX_B;
    localparam int LW     = (LMAX > 1) ? $clog2(LMAX) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [HW-1:0]   hc_r, hc_s;
    logic [LW-1:0]   line_r, line_s;
    logic [LW-1:0]   region_last_s;
    logic            act_slot_s;
    logic            even_slot_s;
    logic            frame_start_s;
    logic            pattern_on_s;
    logic            ready_s;
    logic [15:0]     pix_word_s;
    logic [7:0]      lo_r;

    // Colour-bar palette in RGB565, left to right.
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // RGB888 -> RGB565 packing keeps the top bits of each channel.
    function automatic logic [15:0] to_rgb565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

    // Last line index of the region the FSM is currently in.
    always_comb begin
        region_last_s = {LW{1'b0}};
        case (state_r)
            ST_VSYNC:  region_last_s = LW'(VS_LINES - 1);
            ST_VBACK:  region_last_s = LW'(V_BACK - 1);
            ST_ACTIVE: region_last_s = LW'(V_ACTIVE - 1);
            ST_VFRONT: region_last_s = LW'(V_FRONT - 1);
            default:   region_last_s = {LW{1'b0}};
        endcase
    end

    // Next-state logic: cycle counter within line, line counter within region.
    always_comb begin
        state_s = state_r;
        hc_s    = hc_r;
        line_s  = line_r;
        case (state_r)
            ST_IDLE: begin
                hc_s   = {HW{1'b0}};
                line_s = {LW{1'b0}};
                if (en) begin
                    state_s = ST_VSYNC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT: begin
                if (hc_r == HW'(LP - 1)) begin
                    hc_s = {HW{1'b0}};
                    if (line_r == region_last_s) begin
                        line_s = {LW{1'b0}};
                        case (state_r)
                            ST_VSYNC:  state_s = ST_VBACK;
                            ST_VBACK:  state_s = ST_ACTIVE;
                            ST_ACTIVE: state_s = ST_VFRONT;
                            ST_VFRONT: begin
                                // en is only looked at here, so a frame always completes
                                if (en) begin
                                    state_s = ST_VSYNC;
                                end else begin
                                    state_s = ST_IDLE;
                                end
                            end
                            default:   state_s = ST_IDLE;
                        endcase
                    end else begin
                        line_s = line_r + LW'(1);
                    end
                end else begin
                    hc_s = hc_r + HW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                hc_s    = {HW{1'b0}};
                line_s  = {LW{1'b0}};
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            hc_r    <= {HW{1'b0}};
            line_r  <= {LW{1'b0}};
        end else begin
            state_r <= state_s;
            hc_r    <= hc_s;
            line_r  <= line_s;
        end
    end

    // Byte-slot decode; outputs lag the counters by one registered stage.
    assign act_slot_s    = (state_r == ST_ACTIVE) && (hc_r < HW'(2 * H_ACTIVE));
    assign even_slot_s   = act_slot_s && !hc_r[0];
    assign frame_start_s = (state_r == ST_VSYNC) && (line_r == {LW{1'b0}})
                           && (hc_r == {HW{1'b0}});
    assign ready_s       = even_slot_s && !pattern_on_s;
    assign pixel_ready   = ready_s;

`ifdef DVP_TX_COLORBAR_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic           pattern_r;
    logic [2:0]     bar_idx_s;
    logic [2:0]     unused_bits_s;

    // Pattern selection is frozen for a whole frame at its first cycle.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_r <= 1'b0;
        end else if (frame_start_s) begin
            pattern_r <= pattern_sel;
        end else begin
            pattern_r <= pattern_r;
        end
    end

    // Bar index from pixel position within the line.
    always_comb begin
        bar_idx_s = 3'(hc_r[HW-1:1] / PXW'(BAR_W));
    end

    assign pattern_on_s  = pattern_r;
    assign unused_bits_s = {pixel_data[18:16] ^ {pixel_data[9:8], 1'b0}} ^ pixel_data[2:0];
`else
    logic [2:0]     bar_idx_s;
    logic           unused_bits_s;

    assign pattern_on_s  = 1'b0;
    assign bar_idx_s     = 3'd0;
    // pattern_sel and the colour bits dropped by RGB565 have no function here
    assign unused_bits_s = pattern_sel ^ (^pixel_data[18:16]) ^ (^pixel_data[9:8])
                           ^ (^pixel_data[2:0]);
`endif

    // Pixel word for the current even slot: bars, converted pixel, or zero on underrun.
    always_comb begin
        pix_word_s = 16'h0000;
        if (pattern_on_s) begin
            pix_word_s = bar_color(bar_idx_s);
        end else if (pixel_valid) begin
            pix_word_s = to_rgb565(pixel_data);
        end else begin
            pix_word_s = 16'h0000;
        end
    end

    // Registered video outputs: sync, enable and byte stream.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_o    <= 1'b0;
            de_o    <= 1'b0;
            sof_o   <= 1'b0;
            pdata_o <= 8'h00;
            lo_r    <= 8'h00;
        end else begin
            vs_o  <= (state_r == ST_VSYNC);
            de_o  <= act_slot_s;
            sof_o <= frame_start_s;
            if (even_slot_s) begin
                pdata_o <= pix_word_s[15:8];
                lo_r    <= pix_word_s[7:0];
            end else if (act_slot_s) begin
                pdata_o <= lo_r;
                lo_r    <= lo_r;
            end else begin
                pdata_o <= 8'h00;
                lo_r    <= lo_r;
            end
        end
    end

    // Sticky underrun flag, cleared only when a new frame starts.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_o <= 1'b0;
        end else if (frame_start_s) begin
            underrun_o <= 1'b0;
        end else if (ready_s && !pixel_valid) begin
            underrun_o <= 1'b1;
        end else begin
            underrun_o <= underrun_o;
        end
    end

endmodule

// File: doc/dvp_8bit_tx.md
DVP_8BIT_TX -- requirements
Module: dvp_8bit_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line (even, >=8).
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 144: pclk cycles with de_o low after each line's active bytes.
REQ-004 SHALL have parameters VS_LINES=3, V_BACK=17, V_FRONT=10: line counts of the vsync, back-porch and front-porch regions.
REQ-005 SHALL have one clock and async active-low reset: pclk  in  1  byte clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port en  in  1: frame enable, sampled only at frame boundaries.
REQ-007 SHALL have port pixel_valid  in  1: upstream pixel present.
REQ-008 SHALL have port pixel_data  in  24: RGB888 pixel, {R,G,B}.
REQ-009 SHALL have port pixel_ready  out  1: module takes pixel this cycle.
REQ-010 SHALL have port pattern_sel  in  1: selects internal colour bars (effective only per REQ-031).
REQ-011 SHALL have port vs_o  out  1: vertical sync, active high.
REQ-012 SHALL have port de_o  out  1: href, high while line bytes are valid.
REQ-013 SHALL have port pdata_o  out  8: byte data.
REQ-014 SHALL have ports sof_o  out  1: one-cycle frame-start pulse; underrun_o  out  1: sticky underrun flag.

Function
REQ-015 SHALL use line period LP = 2*H_ACTIVE + H_BLANK cycles for every line in every region.
REQ-016 SHALL run FSM IDLE -> VSYNC (VS_LINES lines) -> VBACK (V_BACK) -> ACTIVE (V_ACTIVE) -> VFRONT (V_FRONT) -> VSYNC if en=1, else IDLE.
REQ-017 SHALL leave IDLE to VSYNC on first pclk with en=1; en falling mid-frame completes the frame.
REQ-018 SHALL drive vs_o=1 for exactly VS_LINES*LP cycles in VSYNC, 0 elsewhere.
REQ-019 SHALL pulse sof_o for one cycle on the first VSYNC cycle of each frame.
REQ-020 SHALL, in each ACTIVE line, drive de_o=1 for exactly 2*H_ACTIVE consecutive cycles from line start, then de_o=0 for H_BLANK cycles.
REQ-021 SHALL assert pixel_ready one cycle before each even byte slot of an active line (combinational from state/counters), H_ACTIVE times per line.
REQ-022 SHALL convert accepted pixel to RGB565 {R[7:3],G[7:2],B[7:3]} and send high byte then low byte; handshake at cycle t -> high byte on pdata_o at t+1, low byte at t+2.
REQ-023 SHALL, if pixel_valid=0 while pixel_ready=1, send 0x0000 for that pixel and set underrun_o.
REQ-024 SHALL clear underrun_o only on sof_o or reset.
REQ-025 SHALL drive pdata_o=0x00 whenever de_o=0.
REQ-026 SHALL register vs_o, de_o, pdata_o, sof_o (no combinational input-to-output paths except pixel_ready).

Reset
REQ-027 SHALL on rst_n=0, at any time, immediately force FSM to IDLE, all counters to 0, vs_o=0, de_o=0, pdata_o=0x00, sof_o=0, underrun_o=0, pixel_ready=0.
REQ-028 SHALL after rst_n release start a complete new frame (REQ-017); no partial frame resumes.

Configuration
REQ-029 SHALL support macro DVP_TX_COLORBAR_EN.
REQ-030 SHALL without macro ignore pattern_sel; behaviour per REQ-021..023.
REQ-031 SHALL with macro, when pattern_sel=1 (latched at sof_o), hold pixel_ready=0, never set underrun_o, and send 8 bars of H_ACTIVE/8 pixels: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 (H_ACTIVE multiple of 8 required).

Verification (H_ACTIVE=8, V_ACTIVE=2, H_BLANK=3, VS_LINES=1, V_BACK=1, V_FRONT=1; LP=19, frame=95 cycles)
REQ-032 SHALL check timing: en=1 held -> vs_o high 19 cycles, sof_o once per 95 cycles, de_o 16-cycle pulses at frame offsets 38 and 57.
REQ-033 SHALL check conversion: pixel_data=0xFF8040 always valid -> pdata_o alternates 0xFC,0x08 during de_o.
REQ-034 SHALL check underrun: pixel_valid=0 for 2nd pixel of line 1 -> bytes 2-3 are 0x00, underrun_o=1 until next sof_o.
REQ-035 SHALL check reset: rst_n low at frame offset 45 -> all outputs 0 same cycle; after release vs_o rises on next en cycle.
REQ-036 SHALL check en drop: en=0 at offset 20 -> frame completes (second de_o pulse present), then IDLE, vs_o stays 0.
REQ-037 SHALL with DVP_TX_COLORBAR_EN and pattern_sel=1 check line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00; pixel_ready never 1.
